// File: rtl/intt_result_drain.sv
// Buffers 8-lane INTT result beats and serialises them into one coefficient per handshake with a flat address.
// Latency: a beat pushed into an empty FIFO presents lane 0 on the next cycle; each beat takes LANES handshakes.
// Backpressure: i_out_ready stalls the serialiser; beats arriving while the FIFO is full are dropped and flagged.
module intt_result_drain #(
    parameter int LANES      = 8,
    parameter int LANE_DW    = 35,
    parameter int BANK_AW    = 9,
    parameter int OUT_DW     = 39,
    parameter int FIFO_DEPTH = 4,
    parameter int N_COEFF    = 4096,
    localparam int LW        = $clog2(LANES),
    localparam int CW        = $clog2(N_COEFF) + 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_start,
    input  logic                       i_intt_we,
    input  logic [LANES*BANK_AW-1:0]   i_intt_addr,
    input  logic [LANES*LANE_DW-1:0]   i_intt_concat,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [LW+BANK_AW-1:0]      o_out_addr,
    output logic [OUT_DW-1:0]          o_out_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_overflow,
    output logic [CW-1:0]              o_emit_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(N_COEFF - 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;

    logic [LANES*BANK_AW-1:0] addr_mem [FIFO_DEPTH];
    logic [LANES*LANE_DW-1:0] data_mem [FIFO_DEPTH];
    logic [PW:0]              wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]            lane_q;
    logic [CW-1:0]            emit_cnt_q;
    logic                     overflow_q, done_q;

    logic run, empty, full, hs, pop, push, ovf_set, final_hs, done_evt;
    logic [LANES*BANK_AW-1:0] head_addr;
    logic [LANES*LANE_DW-1:0] head_data;
    logic [BANK_AW-1:0]       lane_addr;
    logic [LANE_DW-1:0]       lane_data;

    assign run      = (state_q == RUN);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign hs       = run && !empty && i_out_ready;
    assign pop      = hs && (lane_q == LAST_LANE);
    // i_start discards whatever arrives in the same cycle, so it gates both push and overflow.
    assign push     = run && i_intt_we && (!full || pop) && !i_start;
    assign ovf_set  = run && i_intt_we && full && !pop && !i_start;
    assign final_hs = hs && (emit_cnt_q == LAST_CNT);
    assign done_evt = final_hs && !i_start;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (i_start) state_d = RUN;
            RUN: begin
                if (i_start)       state_d = RUN;
                else if (final_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lane_q     <= '0;
            emit_cnt_q <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= done_evt;
            if (i_start || done_evt) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                lane_q   <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (hs)   lane_q   <= lane_q + 1'b1;
            end
            if (i_start)  emit_cnt_q <= '0;
            else if (hs)  emit_cnt_q <= emit_cnt_q + 1'b1;
            if (i_start)      overflow_q <= 1'b0;
            else if (ovf_set) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr_q[PW-1:0]] <= i_intt_addr;
            data_mem[wr_ptr_q[PW-1:0]] <= i_intt_concat;
        end
    end

    assign head_addr = addr_mem[rd_ptr_q[PW-1:0]];
    assign head_data = data_mem[rd_ptr_q[PW-1:0]];

    // Outputs are forced to zero when nothing is presented so storage contents never leak out.
    always_comb begin
        lane_addr   = head_addr[int'(lane_q)*BANK_AW +: BANK_AW];
        lane_data   = head_data[int'(lane_q)*LANE_DW +: LANE_DW];
        o_out_valid = run && !empty;
        o_out_addr  = '0;
        o_out_data  = '0;
        if (o_out_valid) begin
            o_out_addr                = {lane_q, lane_addr};
            o_out_data[LANE_DW-1:0]   = lane_data;
        end
    end

    assign o_busy     = run;
    assign o_done     = done_q;
    assign o_overflow = overflow_q;
    assign o_emit_cnt = emit_cnt_q;

endmodule

// File: tb/tb_intt_result_drain.sv
// Randomised and directed bench for intt_result_drain against a queue-of-coefficients reference model.
module tb_intt_result_drain;
    localparam int LANES = 8;
    localparam int DEPTH = 4;
    localparam int N     = 4096;

    logic         clock = 1'b0;
    logic         reset;
    logic         i_start, i_intt_we, i_out_ready;
    logic [71:0]  i_intt_addr;
    logic [279:0] i_intt_concat;
    logic         o_out_valid, o_busy, o_done, o_overflow;
    logic [11:0]  o_out_addr;
    logic [38:0]  o_out_data;
    logic [12:0]  o_emit_cnt;

    always #5 clock = ~clock;

    intt_result_drain dut (
        .clock(clock), .reset(reset), .i_start(i_start), .i_intt_we(i_intt_we),
        .i_intt_addr(i_intt_addr), .i_intt_concat(i_intt_concat),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_addr(o_out_addr), .o_out_data(o_out_data), .o_busy(o_busy),
        .o_done(o_done), .o_overflow(o_overflow), .o_emit_cnt(o_emit_cnt)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending coefficients in emission order, {addr12, data39}.
    bit          m_run, m_ovf, m_done;
    int          m_cnt;
    logic [50:0] exp_q [$];
    bit          track;
    bit          seen [N];
    int          dup_cnt, done_pulses, hs_cnt;

    task automatic model_clk();
        int sz, beats;
        bit hs, last, full;
        sz    = exp_q.size();
        beats = (sz + LANES - 1) / LANES;
        hs    = m_run && sz > 0 && i_out_ready;
        last  = hs && (sz % LANES == 1);
        full  = (beats == DEPTH);
        if (i_start) begin
            m_run = 1; exp_q.delete(); m_cnt = 0; m_ovf = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_run) begin
                if (hs) begin
                    void'(exp_q.pop_front());
                    m_cnt++;
                end
                if (i_intt_we) begin
                    if (!full || last) begin
                        for (int k = 0; k < LANES; k++)
                            exp_q.push_back({3'(k), i_intt_addr[k*9 +: 9], 4'b0, i_intt_concat[k*35 +: 35]});
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (m_cnt == N) begin
                    m_run = 0; exp_q.delete(); m_done = 1;
                end
            end
        end
    endtask

    task automatic compare();
        bit v;
        v = m_run && exp_q.size() > 0;
        chk("valid", 64'(o_out_valid), 64'(v));
        if (v) begin
            chk("addr", 64'(o_out_addr), 64'(exp_q[0][50:39]));
            chk("data", 64'(o_out_data), 64'(exp_q[0][38:0]));
        end
        chk("busy", 64'(o_busy), 64'(m_run));
        chk("done", 64'(o_done), 64'(m_done));
        chk("overflow", 64'(o_overflow), 64'(m_ovf));
        chk("emit_cnt", 64'(o_emit_cnt), 64'(m_cnt));
        if (o_done) done_pulses++;
    endtask

    task automatic step();
        if (o_out_valid && i_out_ready) begin
            hs_cnt++;
            if (track) begin
                if (seen[o_out_addr]) dup_cnt++;
                seen[o_out_addr] = 1;
            end
        end
        @(posedge clock);
        model_clk();
        @(negedge clock);
        compare();
        i_start   = 0;
        i_intt_we = 0;
    endtask

    task automatic rand_beat();
        for (int k = 0; k < LANES; k++) begin
            i_intt_addr[k*9 +: 9]     = 9'($urandom);
            i_intt_concat[k*35 +: 35] = 35'({$urandom, $urandom});
        end
        i_intt_we = 1;
    endtask

    task automatic do_start();
        i_start = 1;
        step();
    endtask

    task automatic async_reset();
        #2 reset = 0;
        #1;
        chk("rst_valid", 64'(o_out_valid), 64'd0);
        chk("rst_addr", 64'(o_out_addr), 64'd0);
        chk("rst_data", 64'(o_out_data), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_ovf", 64'(o_overflow), 64'd0);
        chk("rst_cnt", 64'(o_emit_cnt), 64'd0);
        m_run = 0; m_ovf = 0; m_done = 0; m_cnt = 0; exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1;
    endtask

    task automatic run_poly(input bit start_at_end);
        done_pulses = 0;
        dup_cnt     = 0;
        for (int a = 0; a < N; a++) seen[a] = 0;
        i_out_ready = 1;
        do_start();
        track = 1;
        for (int s = 0; s < 512*8 + 10; s++) begin
            if (s % 8 == 0 && s / 8 < 512) begin
                for (int k = 0; k < LANES; k++) begin
                    i_intt_addr[k*9 +: 9]     = 9'(s / 8);
                    i_intt_concat[k*35 +: 35] = 35'({$urandom, $urandom});
                end
                i_intt_we = 1;
            end
            if (start_at_end && m_cnt == N - 1 && o_out_valid) i_start = 1;
            step();
        end
        track = 0;
        if (!start_at_end) begin
            chk("poly_done_pulses", 64'(done_pulses), 64'd1);
            chk("poly_busy", 64'(o_busy), 64'd0);
            chk("poly_cnt", 64'(o_emit_cnt), 64'd4096);
            chk("poly_dups", 64'(dup_cnt), 64'd0);
            begin
                int miss = 0;
                for (int a = 0; a < N; a++) if (!seen[a]) miss++;
                chk("poly_missing", 64'(miss), 64'd0);
            end
        end else begin
            chk("late_start_done", 64'(done_pulses), 64'd0);
            chk("late_start_busy", 64'(o_busy), 64'd1);
        end
    endtask

    initial begin
        int h0;
        reset = 0; i_start = 0; i_intt_we = 0; i_out_ready = 0;
        i_intt_addr = '0; i_intt_concat = '0;
        track = 0; hs_cnt = 0; dup_cnt = 0; done_pulses = 0;
        m_run = 0; m_ovf = 0; m_done = 0; m_cnt = 0;
        #1;
        chk("reset_valid", 64'(o_out_valid), 64'd0);
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_cnt", 64'(o_emit_cnt), 64'd0);
        chk("reset_ovf", 64'(o_overflow), 64'd0);
        chk("reset_addr", 64'(o_out_addr), 64'd0);
        chk("reset_data", 64'(o_out_data), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1;

        // Beats while idle must be ignored.
        i_out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            rand_beat();
            step();
        end

        // Directed single beat.
        do_start();
        for (int k = 0; k < LANES; k++) begin
            i_intt_addr[k*9 +: 9]     = 9'(k + 16);
            i_intt_concat[k*35 +: 35] = 35'h1_0000_0000 + 35'(k);
        end
        i_intt_we = 1;
        step();
        for (int k = 0; k < LANES; k++) begin
            chk("t1_addr", 64'(o_out_addr), 64'({3'(k), 9'(k + 16)}));
            chk("t1_data", 64'(o_out_data), 64'h1_0000_0000 + 64'(k));
            step();
        end
        chk("t1_valid_after", 64'(o_out_valid), 64'd0);
        chk("t1_cnt", 64'(o_emit_cnt), 64'd8);

        // Backpressure: ready toggles every cycle over two beats.
        h0 = hs_cnt;
        for (int s = 0; s < 40; s++) begin
            i_out_ready = (s % 2 == 0);
            if (s < 2) rand_beat();
            step();
        end
        chk("bp_outputs", 64'(hs_cnt - h0), 64'd16);

        // Overflow: five beats into a four-deep FIFO with ready low.
        do_start();
        i_out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            rand_beat();
            step();
        end
        chk("ovf_set", 64'(o_overflow), 64'd1);
        h0 = hs_cnt;
        i_out_ready = 1;
        for (int i = 0; i < 40; i++) step();
        chk("ovf_drain", 64'(hs_cnt - h0), 64'd32);

        // A beat on the pop cycle while full is accepted.
        do_start();
        i_out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            rand_beat();
            step();
        end
        i_out_ready = 1;
        for (int i = 0; i < 7; i++) step();
        rand_beat();
        step();
        chk("popfull_ovf", 64'(o_overflow), 64'd0);
        for (int i = 0; i < 40; i++) step();
        chk("popfull_cnt", 64'(o_emit_cnt), 64'd40);

        // Restart after three emitted coefficients.
        do_start();
        rand_beat();
        step();
        for (int i = 0; i < 3; i++) step();
        chk("restart_pre_cnt", 64'(o_emit_cnt), 64'd3);
        do_start();
        chk("restart_cnt", 64'(o_emit_cnt), 64'd0);
        chk("restart_valid", 64'(o_out_valid), 64'd0);

        // Randomised traffic.
        do_start();
        for (int s = 0; s < 3000; s++) begin
            i_out_ready = ($urandom_range(3) != 0);
            if ($urandom_range(5) == 0) rand_beat();
            if ($urandom_range(499) == 0) i_start = 1;
            step();
        end

        run_poly(0);
        run_poly(1);

        // Async reset mid-beat at lane 5, then a clean restart.
        do_start();
        i_out_ready = 1;
        rand_beat();
        step();
        for (int i = 0; i < 5; i++) step();
        chk("mid_lane5", 64'(o_out_addr[11:9]), 64'd5);
        async_reset();
        do_start();
        for (int k = 0; k < LANES; k++) begin
            i_intt_addr[k*9 +: 9]     = 9'(k + 16);
            i_intt_concat[k*35 +: 35] = 35'h1_0000_0000 + 35'(k);
        end
        i_intt_we = 1;
        step();
        chk("post_rst_lane0", 64'(o_out_addr), 64'h010);
        for (int i = 0; i < 10; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
